// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
// delay_pkg : state encoding and protocol constants for the serial SRAM model
// Rev 1.0
// ============================================================================
package delay_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WRITE  = 3'd3,
    S_READ   = 3'd4,
    S_IGNORE = 3'd5
  } sram_state_t;

  localparam logic [7:0] SRAM_CMD_READ  = 8'h03;
  localparam logic [7:0] SRAM_CMD_WRITE = 8'h02;
  localparam int         SRAM_ADDR_BITS = 24;

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// spi_pin_sync : 2-flop synchronizer with rise/fall pulses on the synced value
// Rev 1.0
// ============================================================================
module spi_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  // [1:0] is the synchronizer, [2] remembers the previous synced value
  logic [2:0] r_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sh <= 3'b000;
    else     r_sh <= {r_sh[1:0], pin};
  end

  assign sync = r_sh[1];
  assign rise = r_sh[1] & ~r_sh[2];
  assign fall = ~r_sh[1] & r_sh[2];

endmodule
`default_nettype wire

// File: rtl/spi_sram_responder.sv
`default_nettype none
// ============================================================================
// spi_sram_responder : SPI mode-0 sequential-mode serial SRAM emulator
// Rev 1.0
// ============================================================================
module spi_sram_responder
  import delay_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck_ram,
  input  logic              css_ram,
  input  logic              sdi,
  output logic              sdo,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  logic w_sck_sync, w_sck_rise, w_sck_fall;
  logic w_css_sync, w_css_rise, w_css_fall;
  logic w_sdi, w_sdi_rise, w_sdi_fall;

  spi_pin_sync u_sync_sck (.clk(clk), .rst(rst), .pin(sck_ram),
                           .sync(w_sck_sync), .rise(w_sck_rise), .fall(w_sck_fall));
  spi_pin_sync u_sync_css (.clk(clk), .rst(rst), .pin(css_ram),
                           .sync(w_css_sync), .rise(w_css_rise), .fall(w_css_fall));
  spi_pin_sync u_sync_sdi (.clk(clk), .rst(rst), .pin(sdi),
                           .sync(w_sdi), .rise(w_sdi_rise), .fall(w_sdi_fall));

  sram_state_t                r_state, w_next;
  logic [4:0]                 r_bit_cnt;
  logic [SRAM_ADDR_BITS-1:0]  r_shift;
  logic [7:0]                 r_tx;
  logic [ADDR_W-1:0]          r_addr;
  logic                       r_op_rd, r_fetch, r_load;

  logic [SRAM_ADDR_BITS-1:0]  w_addr_full;
  logic [7:0]                 w_rx_byte;
  logic [ADDR_W-1:0]          w_addr_new, w_addr_inc;
  logic                       w_first_bit, w_shift_en, w_cmd_done, w_addr_done;
  logic                       w_commit, w_next_byte, w_tx_shift, w_byte_end;

  assign w_addr_full = {r_shift[SRAM_ADDR_BITS-2:0], w_sdi};
  assign w_rx_byte   = w_addr_full[7:0];
  assign w_addr_new  = w_addr_full[ADDR_W-1:0];
  assign w_addr_inc  = r_addr + ADDR_W'(1);

  logic w_unused;
  assign w_unused = ^{w_sck_sync, w_css_sync, w_sdi_rise, w_sdi_fall,
                      r_shift[SRAM_ADDR_BITS-1], w_addr_full};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_css_rise) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_css_fall) w_next = S_CMD;
        S_CMD:  if (w_sck_rise && r_bit_cnt == 5'd7)
                  w_next = (w_rx_byte == SRAM_CMD_WRITE || w_rx_byte == SRAM_CMD_READ)
                           ? S_ADDR : S_IGNORE;
        S_ADDR: if (w_sck_rise && r_bit_cnt == 5'(SRAM_ADDR_BITS - 1))
                  w_next = r_op_rd ? S_READ : S_WRITE;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_first_bit = (r_state == S_IDLE) && w_css_fall && w_sck_rise;
    w_shift_en  = w_first_bit || (w_sck_rise &&
                  (r_state == S_CMD || r_state == S_ADDR || r_state == S_WRITE));
    w_cmd_done  = (r_state == S_CMD) && w_sck_rise && (r_bit_cnt == 5'd7) && !w_css_rise;
    w_addr_done = (r_state == S_ADDR) && w_sck_rise && !w_css_rise &&
                  (r_bit_cnt == 5'(SRAM_ADDR_BITS - 1));
    // a byte completed on the same clk css rises still commits
    w_commit    = (r_state == S_WRITE) && w_sck_rise && (r_bit_cnt == 5'd7);
    w_next_byte = (r_state == S_READ) && w_sck_rise && (r_bit_cnt == 5'd7) && !w_css_rise;
    w_tx_shift  = (r_state == S_READ) && w_sck_fall && !w_css_rise;
    w_byte_end  = ((r_state == S_CMD || r_state == S_WRITE || r_state == S_READ) &&
                   r_bit_cnt == 5'd7) ||
                  (r_state == S_ADDR && r_bit_cnt == 5'(SRAM_ADDR_BITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_addr    <= '0;
      r_op_rd   <= 1'b0;
      r_fetch   <= 1'b0;
      r_load    <= 1'b0;
      sdo       <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we  <= 1'b0;
      r_fetch <= 1'b0;
      r_load  <= r_fetch;

      if (r_state == S_IDLE)  r_bit_cnt <= w_first_bit ? 5'd1 : 5'd0;
      else if (w_sck_rise)    r_bit_cnt <= w_byte_end ? 5'd0 : r_bit_cnt + 5'd1;

      if (w_shift_en) r_shift <= w_addr_full;
      if (w_cmd_done) r_op_rd <= (w_rx_byte == SRAM_CMD_READ);

      if (w_addr_done) begin
        r_addr   <= w_addr_new;
        mem_addr <= w_addr_new;
        r_fetch  <= r_op_rd;
      end

      if (w_commit) begin
        mem_we    <= 1'b1;
        mem_addr  <= r_addr;
        mem_wdata <= w_rx_byte;
        r_addr    <= w_addr_inc;
      end

      if (w_next_byte) begin
        r_addr   <= w_addr_inc;
        mem_addr <= w_addr_inc;
        r_fetch  <= 1'b1;
      end

      // memory data arrives two clks after the fetch request
      if (r_load)          r_tx <= mem_rdata;
      else if (w_tx_shift) r_tx <= {r_tx[6:0], 1'b0};

      if (r_state != S_READ || w_css_rise) sdo <= 1'b0;
      else if (w_tx_shift)                 sdo <= r_tx[7];
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
`default_nettype none
// ============================================================================
// tb_spi_sram_responder : directed SPI frames with scoreboarded writes/reads
// Rev 1.0
// ============================================================================
module tb_spi_sram_responder;

  localparam int ADDR_W = 17;
  localparam int HALF   = 50;

  logic              clk, rst, sck_ram, css_ram, sdi, sdo, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [7:0]        pre_data;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  int errors = 0;
  int checks = 0;
  logic [24:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [24:0] wr_e;
  logic        rd_phase;
  logic [7:0]  rd_sh = 8'h00;
  int          rd_n = 0;
  int          sdo_hi_cnt = 0;
  int          cnt0;

  spi_sram_responder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .sck_ram(sck_ram), .css_ram(css_ram), .sdi(sdi),
    .sdo(sdo), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // write monitor: every strobe must match the next expected (addr, data)
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        wr_e = exp_wr.pop_front();
        check("write_addr", 32'(mem_addr), 32'(wr_e[24:8]));
        check("write_data", 32'(mem_wdata), 32'(wr_e[7:0]));
      end
    end
    if (sdo) sdo_hi_cnt++;
  end

  // read monitor: master samples sdo on sck rise
  always @(posedge sck_ram) begin
    if (!rd_phase) begin
      rd_n = 0;
    end else begin
      rd_sh = {rd_sh[6:0], sdo};
      rd_n++;
      if (rd_n == 8) begin
        rd_n = 0;
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read_byte: got 0x%0h, expected none", rd_sh);
        end else begin
          check("read_byte", 32'(rd_sh), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdi = v[i];
      #HALF sck_ram = 1'b1;
      #HALF sck_ram = 1'b0;
    end
  endtask

  task automatic frame_begin();
    #3 css_ram = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF css_ram = 1'b1;
    #(4*HALF);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    bits(cmd, 8); bits(a[23:16], 8); bits(a[15:8], 8); bits(a[7:0], 8);
  endtask

  task automatic write_frame(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [ADDR_W-1:0] ea0, input logic [ADDR_W-1:0] ea1);
    exp_wr.push_back({ea0, d0});
    exp_wr.push_back({ea1, d1});
    frame_begin();
    send_hdr(8'h02, a);
    bits(d0, 8); bits(d1, 8);
    frame_end();
  endtask

  task automatic read_frame(input logic [23:0] a, input logic [7:0] e0, input logic [7:0] e1);
    exp_rd.push_back(e0);
    exp_rd.push_back(e1);
    frame_begin();
    send_hdr(8'h03, a);
    rd_phase = 1'b1;
    bits(8'h00, 8); bits(8'h00, 8);
    rd_phase = 1'b0;
    frame_end();
  endtask

  initial begin
    rst = 1'b1; css_ram = 1'b1; sck_ram = 1'b0; sdi = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; rd_phase = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sdo",       32'(sdo), 32'd0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // basic write burst
    write_frame(24'h000010, 8'hA5, 8'h3C, 17'h00010, 17'h00011);

    // basic read burst from preloaded data
    preload(17'h00010, 8'hA5);
    preload(17'h00011, 8'h3C);
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h3C);
    frame_begin();
    send_hdr(8'h03, 24'h000010);
    check("read_busy", 32'(busy), 32'd1);
    rd_phase = 1'b1;
    bits(8'h00, 8); bits(8'h00, 8);
    rd_phase = 1'b0;
    frame_end();
    check("read_sdo_after_css", 32'(sdo), 32'd0);
    check("read_busy_after_css", 32'(busy), 32'd0);

    // address wrap at the top of the implemented space
    write_frame(24'h01FFFF, 8'h11, 8'h22, 17'h1FFFF, 17'h00000);
    read_frame(24'h01FFFF, 8'h11, 8'h22);

    // aborted write byte must not commit
    preload(17'h00020, 8'h5A);
    preload(17'h00021, 8'h77);
    frame_begin();
    send_hdr(8'h02, 24'h000020);
    bits(8'hC3, 5);
    frame_end();
    read_frame(24'h000020, 8'h5A, 8'h77);

    // unknown command is ignored, sdo stays low
    cnt0 = sdo_hi_cnt;
    frame_begin();
    bits(8'h9F, 8);
    bits(8'h03, 8); bits(8'hFF, 8); bits(8'h00, 8); bits(8'h10, 8);
    frame_end();
    check("ignore_sdo_high_cycles", 32'(sdo_hi_cnt - cnt0), 32'd0);
    read_frame(24'h000010, 8'hA5, 8'h3C);

    // asynchronous reset in the middle of the third read byte
    preload(17'h00012, 8'hFF);
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h3C);
    frame_begin();
    send_hdr(8'h03, 24'h000010);
    rd_phase = 1'b1;
    bits(8'h00, 8); bits(8'h00, 8);
    rd_phase = 1'b0;
    bits(8'h00, 4);
    #40;
    check("pre_reset_sdo", 32'(sdo), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_sdo",    32'(sdo), 32'd0);
    check("async_rst_mem_we", 32'(mem_we), 32'd0);
    check("async_rst_busy",   32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt0 = sdo_hi_cnt;
    #3;
    bits(8'h00, 4);
    bits(8'h02, 8);
    check("post_rst_frame_busy", 32'(busy), 32'd0);
    frame_end();
    check("post_rst_sdo_high_cycles", 32'(sdo_hi_cnt - cnt0), 32'd0);
    read_frame(24'h000010, 8'hA5, 8'h3C);

    repeat (20) @(negedge clk);
    check("pending_writes", 32'(exp_wr.size()), 32'd0);
    check("pending_reads",  32'(exp_rd.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
